// File: rtl/vita_tx_ctx_arbiter_pkg.sv
// Shared types and constants for the VITA TX context-packet arbiter.
// Holds the FSM encoding, fifo36 framing bit positions and control register fields.
package vita_tx_ctx_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int SOF_BIT   = 32;
    localparam int EOF_BIT   = 33;
    localparam int MAX_PORTS = 4;
    localparam int ENA_LSB   = 0;
    localparam int PRIO_LSB  = 8;

    function automatic logic [MAX_PORTS-1:0] port_mask(input int n);
        return MAX_PORTS'((1 << n) - 1);
    endfunction

endpackage

// File: rtl/vita_tx_ctx_arbiter_rr_pick_next.sv
// Rotating priority encoder: first set request after 'last', wrapping.
// Purely combinational; 'last' itself is considered last.
module rr_pick_next
    import vita_tx_ctx_arbiter_pkg::*;
(
    input  logic [MAX_PORTS-1:0] req,
    input  logic [1:0]           last,
    output logic                 found,
    output logic [1:0]           next
);

    logic [1:0] idx;

    always_comb begin
        found = 1'b0;
        next  = '0;
        idx   = '0;
        for (int i = 1; i <= MAX_PORTS; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                next  = idx;
            end
        end
    end

endmodule

// File: rtl/vita_tx_ctx_arbiter.sv
// Packet-aware round-robin arbiter merging up to 4 fifo36 context streams.
// Define VITA_CTX_ARB_STATS_EN to add per-port saturating packet counters on debug.
module vita_tx_ctx_arbiter
    import vita_tx_ctx_arbiter_pkg::*;
#(
    parameter int BASE      = 0,
    parameter int NUM_PORTS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    set_stb,
    input  logic [7:0]              set_addr,
    input  logic [31:0]             set_data,
    input  logic [36*NUM_PORTS-1:0] data_i,
    input  logic [NUM_PORTS-1:0]    src_rdy_i,
    output logic [NUM_PORTS-1:0]    dst_rdy_o,
    output logic [35:0]             data_o,
    output logic                    src_rdy_o,
    input  logic                    dst_rdy_i,
    output logic [1:0]              grant_o,
    output logic [31:0]             debug
);

    localparam logic [MAX_PORTS-1:0] VALID = port_mask(NUM_PORTS);
    localparam logic [1:0] LAST_INIT = 2'(NUM_PORTS - 1);

    state_t state, state_nxt;

    logic [1:0]           grant, last_grant, last_eff;
    logic [1:0]           pick, prio_next, all_next;
    logic [MAX_PORTS-1:0] enable, prio, src_vec;
    logic [MAX_PORTS-1:0] req_all, req_prio;
    logic                 prio_found, all_found, pick_found;
    logic                 clear_pend, pkt_clear, reg_wr;
    logic [35:0]          cur_data;
    logic                 cur_src, xfer_eof;
    logic                 unused_set;

    assign unused_set = ^{set_data[31:12], set_data[7:4]};

    assign src_vec  = MAX_PORTS'(src_rdy_i);
    assign req_all  = src_vec & enable & VALID;
    assign req_prio = req_all & prio;
    // A clear seen in IDLE already steers this cycle's pick.
    assign last_eff = clear ? LAST_INIT : last_grant;

    rr_pick_next u_pick_prio (
        .req   (req_prio),
        .last  (last_eff),
        .found (prio_found),
        .next  (prio_next)
    );

    rr_pick_next u_pick_all (
        .req   (req_all),
        .last  (last_eff),
        .found (all_found),
        .next  (all_next)
    );

    assign pick_found = prio_found | all_found;
    assign pick       = prio_found ? prio_next : all_next;

    always_comb begin
        cur_data = '0;
        cur_src  = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant == 2'(p)) begin
                cur_data = data_i[36*p +: 36];
                cur_src  = src_rdy_i[p];
            end
        end
    end

    assign xfer_eof  = (state == STREAM) && cur_src && dst_rdy_i
                     && cur_data[EOF_BIT];
    assign pkt_clear = clear_pend | clear;
    assign reg_wr    = set_stb && (set_addr == 8'(BASE));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (pick_found) state_nxt = STREAM;
            STREAM: if (xfer_eof)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_o    = '0;
        src_rdy_o = 1'b0;
        dst_rdy_o = '0;
        if (state == STREAM) begin
            data_o    = cur_data;
            src_rdy_o = cur_src;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (grant == 2'(p)) dst_rdy_o[p] = dst_rdy_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant      <= '0;
            last_grant <= LAST_INIT;
            enable     <= 4'hF;
            prio       <= '0;
            clear_pend <= 1'b0;
        end else begin
            if (reg_wr) begin
                enable <= set_data[ENA_LSB  +: MAX_PORTS];
                prio   <= set_data[PRIO_LSB +: MAX_PORTS];
            end
            if (state == IDLE) begin
                if (clear)      last_grant <= LAST_INIT;
                if (pick_found) grant      <= pick;
            end else if (xfer_eof) begin
                last_grant <= pkt_clear ? LAST_INIT : grant;
                clear_pend <= 1'b0;
            end else if (clear) begin
                clear_pend <= 1'b1;
            end
        end
    end

    assign grant_o = grant;

`ifdef VITA_CTX_ARB_STATS_EN
    logic [7:0] cnt [MAX_PORTS];
    logic       stat_clr;

    assign stat_clr = ((state == IDLE) && clear) || (xfer_eof && pkt_clear);

    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            for (int p = 0; p < MAX_PORTS; p++) cnt[p] <= '0;
        end else if (xfer_eof && cnt[grant] != 8'hFF) begin
            cnt[grant] <= cnt[grant] + 8'd1;
        end
    end

    assign debug = {cnt[3], cnt[2], cnt[1], cnt[0]};
`else
    assign debug = {27'd0, clear_pend, state, grant, src_rdy_o};
`endif

endmodule

// File: tb/tb_vita_tx_ctx_arbiter.sv
// Randomized bench for vita_tx_ctx_arbiter against a cycle-level arbitration model.
// Honors VITA_CTX_ARB_STATS_EN for the expected debug word.
module tb_vita_tx_ctx_arbiter;
    import vita_tx_ctx_arbiter_pkg::*;

    localparam int NP   = 2;
    localparam int BASE = 5;

    logic              clk = 1'b0;
    logic              reset, clear, set_stb;
    logic [7:0]        set_addr;
    logic [31:0]       set_data;
    logic [36*NP-1:0]  data_i;
    logic [NP-1:0]     src_rdy_i, dst_rdy_o;
    logic [35:0]       data_o;
    logic              src_rdy_o, dst_rdy_i;
    logic [1:0]        grant_o;
    logic [31:0]       debug;

    vita_tx_ctx_arbiter #(.BASE(BASE), .NUM_PORTS(NP)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .set_data  (set_data),
        .data_i    (data_i),
        .src_rdy_i (src_rdy_i),
        .dst_rdy_o (dst_rdy_o),
        .data_o    (data_o),
        .src_rdy_o (src_rdy_o),
        .dst_rdy_i (dst_rdy_i),
        .grant_o   (grant_o),
        .debug     (debug)
    );

    always #5 clk = ~clk;

    logic [35:0] drv_word [NP];
    logic [35:0] q [NP][$];

    always_comb begin
        for (int p = 0; p < NP; p++) data_i[36*p +: 36] = drv_word[p];
    end

    int n_cmp = 0;
    int n_bad = 0;

    // model state: owner<0 means idle
    int       owner, last, gsel;
    logic [3:0] en, pr;
    bit       pend;
    int       cnt [4];

    int       p_src, p_dst, p_clr, p_set, maxlen;
    logic [NP-1:0] refill;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        last  = NP - 1;
        gsel  = 0;
        en    = 4'hF;
        pr    = 4'h0;
        pend  = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
    endtask

    task automatic gen_pkt(input int p);
        int len;
        logic [35:0] w;
        len = $urandom_range(maxlen, 1);
        for (int i = 0; i < len; i++) begin
            w          = '0;
            w[31:0]    = $urandom;
            w[35:34]   = 2'($urandom);
            w[SOF_BIT] = (i == 0);
            w[EOF_BIT] = (i == len - 1);
            q[p].push_back(w);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (refill[p] && q[p].size() == 0) gen_pkt(p);
            if (q[p].size() > 0) begin
                drv_word[p]  = q[p][0];
                src_rdy_i[p] = ($urandom_range(99) < p_src);
            end else begin
                drv_word[p]  = 36'({$urandom, $urandom});
                src_rdy_i[p] = 1'b0;
            end
        end
        dst_rdy_i = ($urandom_range(99) < p_dst);
        clear     = ($urandom_range(99) < p_clr);
        set_stb   = ($urandom_range(99) < p_set);
        set_addr  = $urandom_range(1) ? 8'(BASE) : 8'(BASE + 1);
        set_data  = $urandom;
    endtask

    task automatic cycle();
        logic          exp_src;
        logic [NP-1:0] exp_dst;
        logic [35:0]   exp_data;
        logic [31:0]   exp_dbg;
        logic [3:0]    req, cand;
        int            ob, le;
        @(negedge clk);
        exp_src  = 1'b0;
        exp_dst  = '0;
        exp_data = '0;
        if (owner >= 0) begin
            exp_data       = drv_word[owner];
            exp_src        = src_rdy_i[owner];
            exp_dst[owner] = dst_rdy_i;
        end
`ifdef VITA_CTX_ARB_STATS_EN
        exp_dbg = {8'(cnt[3]), 8'(cnt[2]), 8'(cnt[1]), 8'(cnt[0])};
`else
        exp_dbg = {27'd0, pend, 1'(owner >= 0), 2'(gsel), exp_src};
`endif
        check("src_rdy_o", src_rdy_o, exp_src);
        check("dst_rdy_o", dst_rdy_o, exp_dst);
        check("data_o", data_o, exp_data);
        check("debug", debug, exp_dbg);
        if (owner >= 0) check("grant_o", grant_o, gsel);

        ob = owner;
        if (reset) begin
            model_reset();
        end else begin
            if (owner < 0) begin
                le = last;
                if (clear) begin
                    last = NP - 1;
                    le   = NP - 1;
                    for (int i = 0; i < 4; i++) cnt[i] = 0;
                end
                req = '0;
                for (int p = 0; p < NP; p++) req[p] = src_rdy_i[p] & en[p];
                cand = ((req & pr) != 0) ? (req & pr) : req;
                for (int k = 1; k <= NP; k++) begin
                    if (owner < 0 && cand[(le + k) % NP]) begin
                        owner = (le + k) % NP;
                        gsel  = owner;
                    end
                end
            end else if (src_rdy_i[owner] && dst_rdy_i && drv_word[owner][EOF_BIT]) begin
                if (pend || clear) begin
                    last = NP - 1;
                    for (int i = 0; i < 4; i++) cnt[i] = 0;
                end else begin
                    last = owner;
                    if (cnt[owner] < 255) cnt[owner]++;
                end
                pend  = 1'b0;
                owner = -1;
            end else if (clear) begin
                pend = 1'b1;
            end
            if (set_stb && set_addr == 8'(BASE)) begin
                en = set_data[3:0];
                pr = set_data[11:8];
            end
        end
        if (ob >= 0 && src_rdy_i[ob] && dst_rdy_i) void'(q[ob].pop_front());

        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wr(input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = 8'(BASE);
        set_data = d;
        cycle();
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        set_stb   = 1'b0;
        set_addr  = '0;
        set_data  = '0;
        src_rdy_i = '0;
        dst_rdy_i = 1'b0;
        for (int p = 0; p < NP; p++) drv_word[p] = '0;
        p_src = 0; p_dst = 0; p_clr = 0; p_set = 0;
        maxlen = 3;
        refill = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle();
        reset = 1'b0;

        refill = '1;
        p_src  = 100;
        p_dst  = 100;
        repeat (60) cycle();

        wr(32'h0000_020F);
        repeat (60) cycle();

        wr(32'h0000_000F);
        maxlen = 5;
        p_dst  = 50;
        repeat (100) cycle();

        p_src = 70;
        p_clr = 3;
        p_set = 3;
        repeat (1500) cycle();

        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (300) cycle();

        p_clr  = 0;
        p_set  = 0;
        p_src  = 100;
        p_dst  = 100;
        maxlen = 1;
        refill = 2'b01;
        wr(32'h0000_0001);
        repeat (700) cycle();
`ifdef VITA_CTX_ARB_STATS_EN
        check("cnt0_saturated", debug[7:0], 8'hFF);
`endif
        refill = '0;
        repeat (10) cycle();
        clear = 1'b1;
        cycle();
`ifdef VITA_CTX_ARB_STATS_EN
        check("cnt0_cleared", debug[7:0], 8'h00);
`endif
        repeat (5) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
